// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-master arbiter (core / DMA loader) for one single-port
//            synchronous memory; round-robin with a bounded burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic          m0_lock,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic          m1_lock,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int              c_HW       = $clog2(MAX_HOLD + 1);
   localparam logic [c_HW-1:0] c_MAX_HOLD = c_HW'(MAX_HOLD);
   localparam logic [c_HW-1:0] c_ONE      = c_HW'(1);

   logic            r_last;
   logic            r_owner;
   logic            r_locked;
   logic [c_HW-1:0] r_hold_cnt;
   logic            r_rd_pend;
   logic            r_rd_id;

   logic            w_win;
   logic            w_gnt0;
   logic            w_gnt1;
   logic            w_any;
   logic            w_g;
   logic            w_g_we;
   logic            w_g_lock;
   logic            w_other_req;
   logic [c_HW-1:0] w_hold_nxt;

   // Contention winner: an unexhausted lock keeps the owner, else alternate.
   assign w_win  = (r_locked && (r_hold_cnt < c_MAX_HOLD)) ? r_owner : ~r_last;
   assign w_gnt0 = reset & m0_req & (~m1_req | ~w_win);
   assign w_gnt1 = reset & m1_req & (~m0_req | w_win);
   assign w_any  = w_gnt0 | w_gnt1;

   assign w_g         = w_gnt1;
   assign w_g_we      = w_gnt1 ? m1_we   : m0_we;
   assign w_g_lock    = w_gnt1 ? m1_lock : m0_lock;
   assign w_other_req = w_gnt1 ? m0_req  : m1_req;

   // Hold count only advances while someone is actually being made to wait.
   always_comb begin
      w_hold_nxt = '0;
      if (w_other_req) begin
         if (w_g != r_owner) begin
            w_hold_nxt = c_ONE;
         end else if (r_hold_cnt == c_MAX_HOLD) begin
            w_hold_nxt = c_MAX_HOLD;
         end else begin
            w_hold_nxt = r_hold_cnt + c_ONE;
         end
      end
   end

   always_comb begin
      mem_adr   = '0;
      mem_wdata = '0;
      if (w_gnt0) begin
         mem_adr   = m0_adr;
         mem_wdata = m0_wdata;
      end else if (w_gnt1) begin
         mem_adr   = m1_adr;
         mem_wdata = m1_wdata;
      end
   end

   assign m0_gnt = w_gnt0;
   assign m1_gnt = w_gnt1;
   assign mem_en = w_any;
   assign mem_we = w_any & w_g_we;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_locked   <= 1'b0;
         r_hold_cnt <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_id    <= 1'b0;
      end else if (w_any) begin
         r_last     <= w_g;
         r_owner    <= w_g;
         r_locked   <= w_g_lock;
         r_hold_cnt <= w_hold_nxt;
         r_rd_pend  <= ~w_g_we;
         r_rd_id    <= w_g;
      end else begin
         r_locked   <= 1'b0;
         r_hold_cnt <= '0;
         r_rd_pend  <= 1'b0;
      end
   end

   // Gating with reset drops a read whose data would land during reset.
   assign m0_rvalid = reset & r_rd_pend & ~r_rd_id;
   assign m1_rvalid = reset & r_rd_pend &  r_rd_id;
   assign rdata     = mem_rdata;

endmodule
`default_nettype wire
